// File: rtl/serial_parity_loader_pkg.sv
// Shared constants and state encoding for the serial parity loader.
package serial_parity_loader_pkg;

    localparam int NBITS    = 8;
    localparam int BITCNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STOP  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/serial_parity_loader_idle_timer.sv
// Reloadable down-counter: expire pulses on the enabled cycle that would take it from 1 to 0.
module idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reload on clear; count down while enabled and not yet exhausted.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CW'(TIMEOUT);
        end else if (en && (cnt_q != CW'(0))) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CW'(TIMEOUT);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero TIMEOUT never expires, so frames wait indefinitely.
    assign expire = (TIMEOUT != 0) && en && !clr && (cnt_q == CW'(1));

endmodule

// File: rtl/serial_parity_loader.sv
// Serial-to-byte loader with parity and one-cycle memory write strobe.
// Optional stop-bit check enabled by defining SERIAL_PARITY_LOADER_STOP_CHECK_EN.
module serial_parity_loader
    import serial_parity_loader_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    input  logic             SVALID,
    output logic             SREADY,
    output logic [0:NBITS-1] DATAIN,
    output logic             PIN,
    output logic             WR,
    output logic             RD,
    output logic             TOUT,
    output logic             FERR,
    output logic [CNT_W-1:0] WCOUNT
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_WRITE = ST_WRITE;
`ifdef SERIAL_PARITY_LOADER_STOP_CHECK_EN
    localparam logic [1:0] S_STOP  = ST_STOP;
`endif

    logic [1:0]          state_q,  state_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [0:NBITS-1]    sreg_q,   sreg_d;
    logic [0:NBITS-1]    datain_q, datain_d;
    logic                pin_q,    pin_d;
    logic                wr_q,     wr_d;
    logic                rd_q,     rd_d;
    logic                sready_q, sready_d;
    logic                tout_q,   tout_d;
    logic                ferr_q,   ferr_d;
    logic [CNT_W-1:0]    wcount_q, wcount_d;

    logic xfer_s;
    logic in_frame_s;
    logic expire_s;

    assign xfer_s = SVALID && sready_q;
`ifdef SERIAL_PARITY_LOADER_STOP_CHECK_EN
    assign in_frame_s = (state_q == S_SHIFT) || (state_q == S_STOP);
`else
    assign in_frame_s = (state_q == S_SHIFT);
`endif

    idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk    (CLK),
        .rst    (RST),
        .clr    (xfer_s || !in_frame_s),
        .en     (in_frame_s && !xfer_s),
        .expire (expire_s)
    );

    // Next-state, shift register and output-register updates.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sreg_d   = sreg_q;
        datain_d = datain_q;
        pin_d    = pin_q;
        wcount_d = wcount_q;
        tout_d   = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (xfer_s) begin
                    sreg_d[0] = SIN;
                    bitcnt_d  = BITCNT_W'(1);
                    state_d   = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (xfer_s) begin
                    sreg_d[bitcnt_q] = SIN;
                    bitcnt_d         = bitcnt_q + BITCNT_W'(1);
                    if (bitcnt_q == BITCNT_W'(NBITS - 1)) begin
`ifdef SERIAL_PARITY_LOADER_STOP_CHECK_EN
                        state_d = S_STOP;
`else
                        state_d  = S_WRITE;
                        datain_d = sreg_d;
                        pin_d    = ^sreg_d;
                        wcount_d = wcount_q + CNT_W'(1);
`endif
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else if (expire_s) begin
                    tout_d   = 1'b1;
                    bitcnt_d = BITCNT_W'(0);
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
`ifdef SERIAL_PARITY_LOADER_STOP_CHECK_EN
            S_STOP: begin
                if (xfer_s && SIN) begin
                    state_d  = S_WRITE;
                    datain_d = sreg_q;
                    pin_d    = ^sreg_q;
                    wcount_d = wcount_q + CNT_W'(1);
                end else if (xfer_s) begin
                    ferr_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (expire_s) begin
                    tout_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STOP;
                end
            end
`endif
            S_WRITE: begin
                bitcnt_d = BITCNT_W'(0);
                state_d  = S_IDLE;
            end
            default: begin
                bitcnt_d = BITCNT_W'(0);
                state_d  = S_IDLE;
            end
        endcase
        // Strobes are registered from the next state so they align with WRITE.
        wr_d     = (state_d == S_WRITE);
        rd_d     = !wr_d;
        sready_d = !wr_d;
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            bitcnt_q <= BITCNT_W'(0);
            sreg_q   <= NBITS'(0);
            datain_q <= NBITS'(0);
            pin_q    <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b1;
            sready_q <= 1'b1;
            tout_q   <= 1'b0;
            ferr_q   <= 1'b0;
            wcount_q <= CNT_W'(0);
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sreg_q   <= sreg_d;
            datain_q <= datain_d;
            pin_q    <= pin_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            sready_q <= sready_d;
            tout_q   <= tout_d;
            ferr_q   <= ferr_d;
            wcount_q <= wcount_d;
        end
    end

    assign SREADY = sready_q;
    assign DATAIN = datain_q;
    assign PIN    = pin_q;
    assign WR     = wr_q;
    assign RD     = rd_q;
    assign TOUT   = tout_q;
    assign FERR   = ferr_q;
    assign WCOUNT = wcount_q;

endmodule
